// File: rtl/wave_adsr_synth.sv
// rtl/wave_adsr_synth.sv - phase-accumulator oscillator with ADSR envelope and enveloped output
module wave_adsr_synth #(
  parameter int DATA_W    = 8,
  parameter int PHASE_W   = 16,
  parameter int HARD_SYNC = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               gate,
  input  logic [1:0]         wave_type,
  input  logic [PHASE_W-1:0] freq_inc,
  input  logic [DATA_W-1:0]  duty,
  input  logic [DATA_W-1:0]  attack_rate,
  input  logic [DATA_W-1:0]  decay_rate,
  input  logic [DATA_W-1:0]  release_rate,
  input  logic [DATA_W-1:0]  sustain_level,
  output logic [DATA_W-1:0]  wave_out,
  output logic [DATA_W-1:0]  env_out,
  output logic [2:0]         env_state,
  output logic               busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ATTACK  = 3'd1;
  localparam logic [2:0] S_DECAY   = 3'd2;
  localparam logic [2:0] S_SUSTAIN = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [DATA_W-1:0] ENV_MAX = {DATA_W{1'b1}};

  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic                gate_q;
  logic [DATA_W-1:0]   env_q, env_d;
  logic [2:0]          state_q, state_d;
  logic [DATA_W-1:0]   wave_q, wave_d;

  logic                gate_rise;
  logic [DATA_W-1:0]   p;
  logic [DATA_W-1:0]   raw;
  logic [2*DATA_W-1:0] prod;

  // One extra bit on envelope arithmetic exposes carry/borrow so the envelope saturates
  logic [DATA_W:0]     att_sum;
  logic [DATA_W:0]     dec_diff;
  logic [DATA_W:0]     rel_diff;
  logic                att_full;
  logic                dec_done;
  logic                rel_done;

  assign gate_rise = gate & ~gate_q;
  assign p         = phase_q[PHASE_W-1 -: DATA_W];

  // Raw waveform from the top phase bits; the falling half of the triangle
  // uses the inverted phase so the ramp mirrors about the midpoint (peak 2^DATA_W-2)
  always_comb begin
    raw = '0;
    case (wave_type)
      2'd0:    raw = p[DATA_W-1] ? {~p[DATA_W-2:0], 1'b0} : {p[DATA_W-2:0], 1'b0};
      2'd1:    raw = (p < duty) ? ENV_MAX : '0;
      2'd2:    raw = p;
      default: raw = '0;
    endcase
  end

  assign prod   = {{DATA_W{1'b0}}, raw} * {{DATA_W{1'b0}}, env_q};
  assign wave_d = prod[2*DATA_W-1:DATA_W];

  // Phase advances every cycle; a note-on optionally restarts the cycle at zero
  always_comb begin
    phase_d = phase_q + freq_inc;
    if ((HARD_SYNC != 0) && gate_rise) begin
      phase_d = '0;
    end
  end

  assign att_sum  = {1'b0, env_q} + {1'b0, attack_rate};
  assign dec_diff = {1'b0, env_q} - {1'b0, decay_rate};
  assign rel_diff = {1'b0, env_q} - {1'b0, release_rate};

  // A zero rate means "jump straight to the segment target"
  assign att_full = (attack_rate == '0) || (att_sum >= {1'b0, ENV_MAX});
  assign dec_done = (decay_rate == '0) || dec_diff[DATA_W] ||
                    (dec_diff[DATA_W-1:0] <= sustain_level);
  assign rel_done = (release_rate == '0) || rel_diff[DATA_W] ||
                    (rel_diff[DATA_W-1:0] == '0);

  // Envelope FSM; a note-off leaves the level untouched for the transition cycle
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    case (state_q)
      S_IDLE: begin
        env_d = '0;
        if (gate_rise) begin
          state_d = S_ATTACK;
        end
      end
      S_ATTACK: begin
        if (!gate) begin
          state_d = S_RELEASE;
        end else if (att_full) begin
          env_d   = ENV_MAX;
          state_d = S_DECAY;
        end else begin
          env_d = att_sum[DATA_W-1:0];
        end
      end
      S_DECAY: begin
        if (!gate) begin
          state_d = S_RELEASE;
        end else if (dec_done) begin
          env_d   = sustain_level;
          state_d = S_SUSTAIN;
        end else begin
          env_d = dec_diff[DATA_W-1:0];
        end
      end
      S_SUSTAIN: begin
        if (!gate) begin
          state_d = S_RELEASE;
        end else begin
          env_d = sustain_level;
        end
      end
      S_RELEASE: begin
        if (gate_rise) begin
          state_d = S_ATTACK;
        end else if (rel_done) begin
          env_d   = '0;
          state_d = S_IDLE;
        end else begin
          env_d = rel_diff[DATA_W-1:0];
        end
      end
      default: begin
        env_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers, cleared immediately by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
      gate_q  <= 1'b0;
      env_q   <= '0;
      state_q <= S_IDLE;
      wave_q  <= '0;
    end else begin
      phase_q <= phase_d;
      gate_q  <= gate;
      env_q   <= env_d;
      state_q <= state_d;
      wave_q  <= wave_d;
    end
  end

  assign wave_out  = wave_q;
  assign env_out   = env_q;
  assign env_state = state_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_wave_adsr_synth.sv
// tb/tb_wave_adsr_synth.sv - self-checking bench for wave_adsr_synth against a behavioural model
module tb_wave_adsr_synth;

  localparam int M_IDLE    = 0;
  localparam int M_ATTACK  = 1;
  localparam int M_DECAY   = 2;
  localparam int M_SUSTAIN = 3;
  localparam int M_RELEASE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        gate;
  logic [1:0]  wave_type;
  logic [15:0] freq_inc;
  logic [7:0]  duty;
  logic [7:0]  attack_rate;
  logic [7:0]  decay_rate;
  logic [7:0]  release_rate;
  logic [7:0]  sustain_level;
  logic [7:0]  wave_out;
  logic [7:0]  env_out;
  logic [2:0]  env_state;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  int m_phase, m_gprev, m_env, m_state, m_wave;

  int exp_env[9] = '{0, 64, 128, 192, 255, 239, 223, 207, 200};
  int exp_st[9]  = '{1, 1, 1, 1, 2, 2, 2, 2, 3};

  wave_adsr_synth #(.DATA_W(8), .PHASE_W(16), .HARD_SYNC(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .gate         (gate),
    .wave_type    (wave_type),
    .freq_inc     (freq_inc),
    .duty         (duty),
    .attack_rate  (attack_rate),
    .decay_rate   (decay_rate),
    .release_rate (release_rate),
    .sustain_level(sustain_level),
    .wave_out     (wave_out),
    .env_out      (env_out),
    .env_state    (env_state),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wave"},  wave_out,      0);
    check({tag, "_env"},   env_out,       0);
    check({tag, "_state"}, env_state,     0);
    check({tag, "_busy"},  busy,          0);
    check({tag, "_phase"}, dut.phase_q,   0);
  endtask

  task automatic model_reset();
    m_phase = 0; m_gprev = 0; m_env = 0; m_state = M_IDLE; m_wave = 0;
  endtask

  function automatic int raw_of(input int wt, input int p, input int d);
    case (wt)
      0:       return (p < 128) ? 2 * p : 2 * (255 - p);
      1:       return (p < d) ? 255 : 0;
      2:       return p;
      default: return 0;
    endcase
  endfunction

  // Advance one clock: predict from current inputs, clock, then compare everything
  task automatic step();
    int a, dr, r, s, f, rise, g, nphase, nenv, nstate, nwave;
    a = attack_rate; dr = decay_rate; r = release_rate; s = sustain_level;
    f = freq_inc; g = gate;
    rise   = (g == 1 && m_gprev == 0) ? 1 : 0;
    nwave  = (raw_of(wave_type, m_phase / 256, duty) * m_env) / 256;
    nphase = rise ? 0 : (m_phase + f) % 65536;
    nenv   = m_env;
    nstate = m_state;
    case (m_state)
      M_IDLE: begin
        nenv = 0;
        if (rise) nstate = M_ATTACK;
      end
      M_ATTACK: begin
        if (!g) nstate = M_RELEASE;
        else if (a == 0 || m_env + a >= 255) begin nenv = 255; nstate = M_DECAY; end
        else nenv = m_env + a;
      end
      M_DECAY: begin
        if (!g) nstate = M_RELEASE;
        else if (dr == 0 || m_env - dr <= s) begin nenv = s; nstate = M_SUSTAIN; end
        else nenv = m_env - dr;
      end
      M_SUSTAIN: begin
        if (!g) nstate = M_RELEASE;
        else nenv = s;
      end
      default: begin
        if (rise) nstate = M_ATTACK;
        else if (r == 0 || m_env - r <= 0) begin nenv = 0; nstate = M_IDLE; end
        else nenv = m_env - r;
      end
    endcase
    @(posedge clk);
    #1;
    m_phase = nphase; m_gprev = g; m_env = nenv; m_state = nstate; m_wave = nwave;
    check("env_out",   env_out,     m_env);
    check("env_state", env_state,   m_state);
    check("wave_out",  wave_out,    m_wave);
    check("busy",      busy,        (m_state != M_IDLE));
    check("phase",     dut.phase_q, m_phase);
  endtask

  initial begin
    int cnt_a, cnt_b, mx;
    reset = 1'b1; gate = 1'b0; wave_type = 2'd3; freq_inc = 16'h0000; duty = 8'd0;
    attack_rate = 8'd0; decay_rate = 8'd0; release_rate = 8'd0; sustain_level = 8'd0;
    #2;
    check_zero("rst_initial");
    @(posedge clk); #1;
    check_zero("rst_held");
    reset = 1'b0;
    model_reset();
    step();
    step();

    // Classic ADSR trajectory with fixed expected levels
    attack_rate = 8'd64; decay_rate = 8'd16; sustain_level = 8'd200; release_rate = 8'd100;
    gate = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      check("adsr_env", env_out, exp_env[i]);
      check("adsr_state", env_state, exp_st[i]);
    end
    step();
    step();
    gate = 1'b0;
    step();
    check("rel_hold_env", env_out, 200);
    check("rel_hold_state", env_state, 4);
    step();
    check("rel_step_env", env_out, 100);
    step();
    check("rel_end_env", env_out, 0);
    check("rel_end_state", env_state, 0);

    // Asynchronous reset in the middle of SUSTAIN, with gate still high on release
    wave_type = 2'd2; freq_inc = 16'h0100;
    gate = 1'b1;
    for (int i = 0; i < 11; i++) step();
    check("pre_rst_state", env_state, 3);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check_zero("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_zero("rst_hold");
    end
    reset = 1'b0;
    model_reset();
    step();
    check("post_rst_rise", env_state, 1);
    gate = 1'b0;
    step();
    step();

    // Note-off during ATTACK, then note-on again during RELEASE
    attack_rate = 8'd64; release_rate = 8'd100;
    gate = 1'b1;
    step(); step(); step();
    check("retrig_att_env", env_out, 128);
    gate = 1'b0;
    step();
    check("retrig_rel_env", env_out, 128);
    check("retrig_rel_state", env_state, 4);
    step();
    check("retrig_rel2_env", env_out, 28);
    gate = 1'b1;
    step();
    check("retrig_att_hold", env_out, 28);
    check("retrig_att_state", env_state, 1);
    check("retrig_phase0", dut.phase_q, 0);
    step();
    check("retrig_att1", env_out, 92);
    step();
    check("retrig_att2", env_out, 156);
    gate = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Square wave with instantaneous envelope
    wave_type = 2'd1; duty = 8'd64; freq_inc = 16'h0400;
    attack_rate = 8'd0; decay_rate = 8'd0; release_rate = 8'd0; sustain_level = 8'd255;
    gate = 1'b1;
    for (int i = 0; i < 4; i++) step();
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (wave_out == 8'd254) cnt_a++;
      else if (wave_out == 8'd0) cnt_b++;
    end
    check("square_high_cnt", cnt_a, 16);
    check("square_low_cnt", cnt_b, 48);

    // Sawtooth at full envelope
    wave_type = 2'd2; freq_inc = 16'h0100;
    step(); step();
    cnt_a = 0; mx = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (wave_out == 8'd0) cnt_a++;
      if (int'(wave_out) > mx) mx = wave_out;
    end
    check("saw_zero_cnt", cnt_a, 2);
    check("saw_max", mx, 254);

    // Triangle peak and symmetry, then silence
    wave_type = 2'd0; freq_inc = 16'h0080;
    step(); step();
    cnt_a = 0; mx = 0;
    for (int i = 0; i < 512; i++) begin
      step();
      if (wave_out == 8'd253) cnt_a++;
      if (int'(wave_out) > mx) mx = wave_out;
    end
    check("tri_max", mx, 253);
    check("tri_peak_cnt", cnt_a, 4);
    wave_type = 2'd3;
    step(); step();
    check("silence", wave_out, 0);

    // Randomised operation against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) gate = ~gate;
      if ($urandom_range(0, 31) == 0) begin
        attack_rate   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        decay_rate    = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        release_rate  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        sustain_level = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 63) == 0) begin
        wave_type = 2'($urandom_range(0, 3));
        freq_inc  = 16'($urandom);
        duty      = 8'($urandom);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
